// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding, parameter string
// constants and a small elaboration-time helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_FILTER  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam string ORDER_UP   = "UP";
    localparam string ORDER_DOWN = "DOWN";
    localparam string POL_HIGH   = "HIGH";
    localparam string POL_LOW    = "LOW";

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after STAGES rising edges.
module reset_seq_sync
    import reset_seq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_arst,
    output logic o_rst_ok
);

    (* async_reg = "true" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_ok = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: filters the synchronised reset release, then releases the
// per-channel resets one at a time, STEP_CYCLES apart, in the configured order.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int    CHANNELS       = 4,
    parameter int    SYNC_STAGES    = 2,
    parameter int    FILTER_CYCLES  = 16,
    parameter int    STEP_CYCLES    = 8,
    parameter string ORDER          = "UP",
    parameter string OUT_RST_ACTIVE = "HIGH"
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic                i_sw_rst,
    output logic [CHANNELS-1:0] o_srst,
    output logic                o_ready
);

    localparam int CNT_W = $clog2(max_int(FILTER_CYCLES, STEP_CYCLES) + 1);
    localparam int IDX_W = $clog2(CHANNELS + 1);

    localparam bit                  ORDER_IS_DOWN = (ORDER == ORDER_DOWN);
    localparam logic                ASSERTED      = (OUT_RST_ACTIVE == POL_LOW) ? 1'b0 : 1'b1;
    localparam logic [CHANNELS-1:0] ALL_ASSERTED  = {CHANNELS{ASSERTED}};

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(CHANNELS - 1);

    logic rst_ok;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [CHANNELS-1:0]  srst_q,  srst_d;
    logic                 ready_q, ready_d;

    reset_seq_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk    (i_clk),
        .i_arst   (i_arst),
        .o_rst_ok (rst_ok)
    );

    // One-hot mask of the channel released at position idx of the release order.
    function automatic logic [CHANNELS-1:0] chan_mask(input logic [IDX_W-1:0] idx);
        int ch;
        ch = ORDER_IS_DOWN ? (CHANNELS - 1 - int'(idx)) : int'(idx);
        return CHANNELS'(1) << ch;
    endfunction

    function automatic logic [CHANNELS-1:0] release_ch(input logic [CHANNELS-1:0] cur,
                                                       input logic [CHANNELS-1:0] mask);
        return ASSERTED ? (cur & ~mask) : (cur | mask);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        srst_d  = srst_q;
        ready_d = ready_q;

        // A software request and a lost synchronised reset look identical here.
        if (i_sw_rst || !rst_ok) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            srst_d  = ALL_ASSERTED;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end
                ST_FILTER: begin
                    if (cnt_q == FILTER_LAST) begin
                        cnt_d  = '0;
                        srst_d = release_ch(srst_q, chan_mask('0));
                        if (CHANNELS == 1) begin
                            state_d = ST_DONE;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d  = '0;
                        srst_d = release_ch(srst_q, chan_mask(idx_q));
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            srst_q  <= ALL_ASSERTED;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            srst_q  <= srst_d;
            ready_q <= ready_d;
        end
    end

    assign o_srst  = srst_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: three instances (UP, DOWN, single-channel active-low)
// driven in lockstep and compared against an edge-count reference model.
`timescale 1ns/100ps
module tb_reset_seq;

    localparam int CH   = 3;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int STEP = 3;

    logic          clk;
    logic          arst;
    logic          sw;
    logic [CH-1:0] up_srst, dn_srst;
    logic          up_rdy, dn_rdy;
    logic [0:0]    lo_srst;
    logic          lo_rdy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edges since i_arst rose, and consecutive "go" edges.
    int m_since;
    int m_run;

    reset_seq #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .STEP_CYCLES(STEP),
                .ORDER("UP"), .OUT_RST_ACTIVE("HIGH")) dut_up (
        .i_clk(clk), .i_arst(arst), .i_sw_rst(sw), .o_srst(up_srst), .o_ready(up_rdy));

    reset_seq #(.CHANNELS(CH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .STEP_CYCLES(STEP),
                .ORDER("DOWN"), .OUT_RST_ACTIVE("HIGH")) dut_dn (
        .i_clk(clk), .i_arst(arst), .i_sw_rst(sw), .o_srst(dn_srst), .o_ready(dn_rdy));

    reset_seq #(.CHANNELS(1), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .STEP_CYCLES(STEP),
                .ORDER("UP"), .OUT_RST_ACTIVE("LOW")) dut_lo (
        .i_clk(clk), .i_arst(arst), .i_sw_rst(sw), .o_srst(lo_srst), .o_ready(lo_rdy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            m_since <= 0;
            m_run   <= 0;
        end else begin
            m_since <= (m_since < 100) ? m_since + 1 : m_since;
            m_run   <= (m_since >= SYNC && !sw) ? ((m_run < 100000) ? m_run + 1 : m_run) : 0;
        end
    end

    function automatic int rel_count(input int run, input int nch);
        int r;
        if (run < 1 + FILT) return 0;
        r = 1 + (run - 1 - FILT) / STEP;
        return (r > nch) ? nch : r;
    endfunction

    function automatic logic [31:0] exp_srst(input int run, input int nch, input bit down, input bit low);
        logic [31:0] v;
        int r;
        bit released;
        v = '0;
        r = rel_count(run, nch);
        for (int i = 0; i < nch; i++) begin
            released = down ? (i >= nch - r) : (i < r);
            v[i] = low ? released : !released;
        end
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".up_srst"}, 32'(up_srst), exp_srst(m_run, CH, 1'b0, 1'b0));
        check_val({tag, ".up_rdy"},  32'(up_rdy),  32'(rel_count(m_run, CH) == CH));
        check_val({tag, ".dn_srst"}, 32'(dn_srst), exp_srst(m_run, CH, 1'b1, 1'b0));
        check_val({tag, ".dn_rdy"},  32'(dn_rdy),  32'(rel_count(m_run, CH) == CH));
        check_val({tag, ".lo_srst"}, 32'(lo_srst), exp_srst(m_run, 1, 1'b0, 1'b1));
        check_val({tag, ".lo_rdy"},  32'(lo_rdy),  32'(rel_count(m_run, 1) == 1));
    endtask

    initial begin
        int r;
        int sw_hold;
        bit arst_low;
        arst = 1'b0;
        sw   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst.up_srst", 32'(up_srst), 32'h7);
        check_val("rst.up_rdy",  32'(up_rdy),  32'h0);
        check_val("rst.lo_srst", 32'(lo_srst), 32'h0);
        check_all("rst");

        // Clean release from power-on reset.
        arst = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            check_all($sformatf("rel%0d", e));
            if (e == 6) begin
                check_val("e6.up", 32'(up_srst), 32'h7);
                check_val("e6.lo", 32'(lo_srst), 32'h0);
            end
            if (e == 7) begin
                check_val("e7.up", 32'(up_srst), 32'h6);
                check_val("e7.dn", 32'(dn_srst), 32'h3);
                check_val("e7.lo", 32'(lo_srst), 32'h1);
                check_val("e7.lo_rdy", 32'(lo_rdy), 32'h1);
            end
            if (e == 10) begin
                check_val("e10.up", 32'(up_srst), 32'h4);
                check_val("e10.dn", 32'(dn_srst), 32'h1);
            end
            if (e == 12) check_val("e12.up_rdy", 32'(up_rdy), 32'h0);
            if (e == 13) begin
                check_val("e13.up", 32'(up_srst), 32'h0);
                check_val("e13.dn", 32'(dn_srst), 32'h0);
                check_val("e13.up_rdy", 32'(up_rdy), 32'h1);
            end
        end

        // Short i_arst glitch in the middle of the release sequence.
        #1 arst = 1'b0;
        #1 arst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            check_all($sformatf("pre%0d", e));
        end
        #1 arst = 1'b0;
        #0.5;
        check_val("glitch.up", 32'(up_srst), 32'h7);
        check_val("glitch.up_rdy", 32'(up_rdy), 32'h0);
        check_val("glitch.dn", 32'(dn_srst), 32'h7);
        check_all("glitch");
        #0.5 arst = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
            check_all($sformatf("post%0d", e));
            if (e == 12) check_val("post12.up_rdy", 32'(up_rdy), 32'h0);
            if (e == 13) begin
                check_val("post13.up", 32'(up_srst), 32'h0);
                check_val("post13.up_rdy", 32'(up_rdy), 32'h1);
            end
        end

        // Software reset held for two cycles while DONE.
        sw = 1'b1;
        @(negedge clk);
        check_val("sw1.up", 32'(up_srst), 32'h7);
        check_val("sw1.up_rdy", 32'(up_rdy), 32'h0);
        check_all("sw1");
        @(negedge clk);
        check_all("sw2");
        sw = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_all($sformatf("swr%0d", k));
            if (k == 4) check_val("swr4.up", 32'(up_srst), 32'h7);
            if (k == 5) begin
                check_val("swr5.up", 32'(up_srst), 32'h6);
                check_val("swr5.dn", 32'(dn_srst), 32'h3);
                check_val("swr5.lo_rdy", 32'(lo_rdy), 32'h1);
            end
        end

        // Randomised mix of software resets, short glitches and longer resets.
        sw_hold  = 0;
        arst_low = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            check_all("rnd");
            if (arst_low) begin
                arst     = 1'b1;
                arst_low = 1'b0;
            end
            r = int'($urandom_range(0, 99));
            if (sw_hold > 0) begin
                sw = 1'b1;
                sw_hold--;
            end else begin
                sw = 1'b0;
                if (r < 2) sw_hold = int'($urandom_range(1, 3));
            end
            if (r == 2) begin
                #1 arst = 1'b0;
                #1;
                check_all("rnd_glitch");
                arst = 1'b1;
            end else if (r == 3) begin
                arst     = 1'b0;
                arst_low = 1'b1;
            end
        end
        arst = 1'b1;
        sw   = 1'b0;
        repeat (20) @(negedge clk);
        check_all("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
